// File: rtl/rgbw_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : rgbw_frame_packer_if
// Description : Byte-stream valid/ready channel between the frame packer and
//               the byte-level SPI shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rgbw_frame_packer_if;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_byte,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_byte,
      input  tx_valid,
      output tx_ready
   );
endinterface
`default_nettype wire

// File: rtl/rgbw_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : rgbw_frame_packer
// Description : Snapshots the RGBW colour/control registers and serialises
//               them as a sync-prefixed byte frame to the SPI shifter.
//               Define RGBW_FRAME_CHECKSUM_EN to append an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module rgbw_frame_packer #(
   parameter logic [7:0] SYNC_BYTE = 8'h55
) (
   input  wire        clk,
   input  wire        reset,
   input  wire        clk_half,
   input  wire        start,
   input  wire  [7:0] lint_in,
   input  wire  [7:0] colorIdx_in,
   input  wire  [7:0] red_in,
   input  wire  [7:0] green_in,
   input  wire  [7:0] blue_in,
   input  wire  [7:0] white_in,
   input  wire  [7:0] mode_in,
   rgbw_frame_packer_if.master tx,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

`ifdef RGBW_FRAME_CHECKSUM_EN
   localparam logic [3:0] c_LAST_IDX = 4'd8;
`else
   localparam logic [3:0] c_LAST_IDX = 4'd7;
`endif

   state_t     r_state, w_state_nxt;
   logic [3:0] r_idx, w_idx_nxt, w_sel_idx;
   logic [7:0] r_tx_byte, w_tx_byte_nxt, w_sel_byte;
   logic       r_tx_valid, w_tx_valid_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_frame_done, w_frame_done_nxt;
   logic       w_capture, w_snap_clear;

   logic [7:0] r_lint, r_color_idx, r_red, r_green, r_blue, r_white, r_mode;

`ifdef RGBW_FRAME_CHECKSUM_EN
   logic [7:0] w_csum;
   assign w_csum = r_lint ^ r_color_idx ^ r_red ^ r_green ^ r_blue ^ r_white ^ r_mode;
`endif

   // Byte that follows the current one in frame order.
   assign w_sel_idx = r_idx + 4'd1;

   always_comb begin
      w_sel_byte = 8'h00;
      case (w_sel_idx)
         4'd1:    w_sel_byte = r_lint;
         4'd2:    w_sel_byte = r_color_idx;
         4'd3:    w_sel_byte = r_red;
         4'd4:    w_sel_byte = r_green;
         4'd5:    w_sel_byte = r_blue;
         4'd6:    w_sel_byte = r_white;
         4'd7:    w_sel_byte = r_mode;
`ifdef RGBW_FRAME_CHECKSUM_EN
         4'd8:    w_sel_byte = w_csum;
`endif
         default: w_sel_byte = 8'h00;
      endcase
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_tx_byte_nxt    = r_tx_byte;
      w_tx_valid_nxt   = r_tx_valid;
      w_busy_nxt       = r_busy;
      w_frame_done_nxt = 1'b0;
      w_capture        = 1'b0;
      w_snap_clear     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_capture      = 1'b1;
               w_tx_byte_nxt  = SYNC_BYTE;
               w_tx_valid_nxt = 1'b1;
               w_busy_nxt     = 1'b1;
               w_idx_nxt      = 4'd0;
               w_state_nxt    = S_SEND;
            end
         end
         S_SEND: begin
            if (r_idx > c_LAST_IDX) begin
               // Unreachable index: recover to a clean idle state.
               w_state_nxt    = S_IDLE;
               w_idx_nxt      = 4'd0;
               w_tx_byte_nxt  = 8'h00;
               w_tx_valid_nxt = 1'b0;
               w_busy_nxt     = 1'b0;
               w_snap_clear   = 1'b1;
            end else if (r_tx_valid && tx.tx_ready) begin
               if (r_idx == c_LAST_IDX) begin
                  w_state_nxt      = S_IDLE;
                  w_idx_nxt        = 4'd0;
                  w_tx_byte_nxt    = 8'h00;
                  w_tx_valid_nxt   = 1'b0;
                  w_busy_nxt       = 1'b0;
                  w_frame_done_nxt = 1'b1;
               end else begin
                  w_idx_nxt     = w_sel_idx;
                  w_tx_byte_nxt = w_sel_byte;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_idx        <= 4'd0;
         r_tx_byte    <= 8'h00;
         r_tx_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (!clk_half) begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_tx_byte    <= w_tx_byte_nxt;
         r_tx_valid   <= w_tx_valid_nxt;
         r_busy       <= w_busy_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lint      <= 8'h00;
         r_color_idx <= 8'h00;
         r_red       <= 8'h00;
         r_green     <= 8'h00;
         r_blue      <= 8'h00;
         r_white     <= 8'h00;
         r_mode      <= 8'h00;
      end else if (!clk_half) begin
         if (w_capture) begin
            r_lint      <= lint_in;
            r_color_idx <= colorIdx_in;
            r_red       <= red_in;
            r_green     <= green_in;
            r_blue      <= blue_in;
            r_white     <= white_in;
            r_mode      <= mode_in;
         end else if (w_snap_clear) begin
            r_lint      <= 8'h00;
            r_color_idx <= 8'h00;
            r_red       <= 8'h00;
            r_green     <= 8'h00;
            r_blue      <= 8'h00;
            r_white     <= 8'h00;
            r_mode      <= 8'h00;
         end
      end
   end

   assign tx.tx_byte  = r_tx_byte;
   assign tx.tx_valid = r_tx_valid;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_rgbw_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgbw_frame_packer
// Description : Directed self-checking bench for rgbw_frame_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgbw_frame_packer;

`ifdef RGBW_FRAME_CHECKSUM_EN
   localparam int c_NBYTES = 9;
`else
   localparam int c_NBYTES = 8;
`endif

   logic       clk;
   logic       reset;
   logic       clk_half;
   logic       start;
   logic [7:0] lint_in, colorIdx_in, red_in, green_in, blue_in, white_in, mode_in;
   logic       busy, frame_done;
   logic [7:0] exp_bytes [0:8];
   int         n_checks;
   int         n_fail;

   rgbw_frame_packer_if bus ();

   rgbw_frame_packer #(.SYNC_BYTE(8'h55)) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_half    (clk_half),
      .start       (start),
      .lint_in     (lint_in),
      .colorIdx_in (colorIdx_in),
      .red_in      (red_in),
      .green_in    (green_in),
      .blue_in     (blue_in),
      .white_in    (white_in),
      .mode_in     (mode_in),
      .tx          (bus.master),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Enable alternates so every second rising edge is an enabled edge.
   initial clk_half = 1'b0;
   always @(negedge clk) clk_half = ~clk_half;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic en_edge;
      do @(posedge clk); while (clk_half !== 1'b0);
      #1;
   endtask

   task automatic set_payload(input logic [7:0] v);
      lint_in = v; colorIdx_in = v; red_in = v; green_in = v;
      blue_in = v; white_in = v; mode_in = v;
   endtask

   task automatic set_std_payload;
      lint_in = 8'h80; colorIdx_in = 8'h03; red_in = 8'h11; green_in = 8'h22;
      blue_in = 8'h33; white_in = 8'h44; mode_in = 8'h01;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_checks++; if (bus.tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte); end
      n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      @(negedge clk);
      reset = 1'b1;
      en_edge();
   endtask

   task automatic test_basic_frame;
      set_std_payload();
      bus.tx_ready = 1'b1;
      start = 1'b1;
      en_edge();
      start = 1'b0;
      n_checks++; if (bus.tx_byte !== 8'h55 || bus.tx_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL basic_accept: got byte=%h valid=%b busy=%b want 55/1/1", bus.tx_byte, bus.tx_valid, busy); end
      for (int i = 1; i < c_NBYTES; i++) begin
         en_edge();
         n_checks++; if (bus.tx_byte !== exp_bytes[i] || bus.tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_byte%0d: got %h valid=%b want %h", i, bus.tx_byte, bus.tx_valid, exp_bytes[i]); end
      end
      en_edge();
      n_checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b1 || bus.tx_byte !== 8'h00) begin
         n_fail++; $display("FAIL basic_done: got valid=%b busy=%b done=%b byte=%h want 0/0/1/00", bus.tx_valid, busy, frame_done, bus.tx_byte); end
      en_edge();
      n_checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_done_clear: got done=%b busy=%b want 0/0", frame_done, busy); end
   endtask

   task automatic test_stall;
      set_std_payload();
      bus.tx_ready = 1'b1;
      start = 1'b1;
      en_edge();
      start = 1'b0;
      en_edge();
      en_edge();
      n_checks++; if (bus.tx_byte !== 8'h03) begin n_fail++; $display("FAIL stall_pre: got %h want 03", bus.tx_byte); end
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         en_edge();
         n_checks++; if (bus.tx_byte !== 8'h03 || bus.tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold%0d: got %h valid=%b want 03/1", i, bus.tx_byte, bus.tx_valid); end
      end
      bus.tx_ready = 1'b1;
      for (int i = 3; i < c_NBYTES; i++) begin
         en_edge();
         n_checks++; if (bus.tx_byte !== exp_bytes[i]) begin
            n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, bus.tx_byte, exp_bytes[i]); end
      end
      en_edge();
      n_checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL stall_done: got done=%b busy=%b want 1/0", frame_done, busy); end
      en_edge();
   endtask

   task automatic test_start_ignored;
      set_std_payload();
      bus.tx_ready = 1'b1;
      start = 1'b1;
      en_edge();
      start = 1'b0;
      en_edge();
      set_payload(8'hFF);
      start = 1'b1;
      en_edge();
      start = 1'b0;
      for (int i = 2; i < c_NBYTES; i++) begin
         if (i > 2) en_edge();
         n_checks++; if (bus.tx_byte !== exp_bytes[i]) begin
            n_fail++; $display("FAIL ignore_byte%0d: got %h want %h", i, bus.tx_byte, exp_bytes[i]); end
      end
      en_edge();
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL ignore_done: got %b want 1", frame_done); end
      for (int i = 0; i < 3; i++) begin
         en_edge();
         n_checks++; if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL ignore_no_second%0d: got busy=%b valid=%b want 0/0", i, busy, bus.tx_valid); end
      end
      set_std_payload();
   endtask

   task automatic test_ready_off_phase;
      set_std_payload();
      bus.tx_ready = 1'b0;
      start = 1'b1;
      en_edge();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #5 bus.tx_ready = 1'b1;
         @(posedge clk);
         #1 bus.tx_ready = 1'b0;
         en_edge();
         n_checks++; if (bus.tx_byte !== 8'h55 || bus.tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL offphase_hold%0d: got %h valid=%b want 55/1", i, bus.tx_byte, bus.tx_valid); end
      end
      bus.tx_ready = 1'b1;
      for (int i = 1; i < c_NBYTES; i++) en_edge();
      n_checks++; if (bus.tx_byte !== exp_bytes[c_NBYTES-1]) begin
         n_fail++; $display("FAIL offphase_last: got %h want %h", bus.tx_byte, exp_bytes[c_NBYTES-1]); end
      en_edge();
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL offphase_done: got %b want 1", frame_done); end
      en_edge();
   endtask

   task automatic test_reset_abort;
      set_std_payload();
      bus.tx_ready = 1'b1;
      start = 1'b1;
      en_edge();
      start = 1'b0;
      repeat (4) en_edge();
      n_checks++; if (bus.tx_byte !== 8'h22) begin n_fail++; $display("FAIL abort_pre: got %h want 22", bus.tx_byte); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || bus.tx_byte !== 8'h00) begin
         n_fail++; $display("FAIL abort_async: got valid=%b busy=%b done=%b byte=%h want 0/0/0/00", bus.tx_valid, busy, frame_done, bus.tx_byte); end
      @(negedge clk);
      reset = 1'b1;
      en_edge();
      start = 1'b1;
      en_edge();
      start = 1'b0;
      n_checks++; if (bus.tx_byte !== 8'h55 || bus.tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL abort_restart: got %h valid=%b want 55/1", bus.tx_byte, bus.tx_valid); end
      for (int i = 1; i < c_NBYTES; i++) begin
         en_edge();
         n_checks++; if (bus.tx_byte !== exp_bytes[i]) begin
            n_fail++; $display("FAIL abort_byte%0d: got %h want %h", i, bus.tx_byte, exp_bytes[i]); end
      end
      en_edge();
      n_checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_done: got done=%b busy=%b want 1/0", frame_done, busy); end
      en_edge();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_bytes[0] = 8'h55; exp_bytes[1] = 8'h80; exp_bytes[2] = 8'h03;
      exp_bytes[3] = 8'h11; exp_bytes[4] = 8'h22; exp_bytes[5] = 8'h33;
      exp_bytes[6] = 8'h44; exp_bytes[7] = 8'h01; exp_bytes[8] = 8'hC6;
      start        = 1'b0;
      bus.tx_ready = 1'b0;
      set_payload(8'h00);

      test_reset();
      test_basic_frame();
      test_stall();
      test_start_ignored();
      test_ready_off_phase();
      test_reset_abort();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
